// File: rtl/stackq_pkg.sv
// -----------------------------------------------------------------------------
// stackq_pkg: shared types and helpers for the stackq_buf FIFO/LIFO buffer.
//   mode_t      : buffer ordering mode (MODE_FIFO = 0, MODE_LIFO = 1)
//   usedw_next  : next fill level from the write/read accept strobes
// -----------------------------------------------------------------------------
package stackq_pkg;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } mode_t;

    // Wide enough for any practical AWIDTH; callers cast down to AWIDTH+1.
    localparam int USEDW_W = 16;

    // +1 on write only, -1 on read only, unchanged on both or neither.
    function automatic logic [USEDW_W-1:0] usedw_next(
        input logic [USEDW_W-1:0] cur,
        input logic               wr_acc,
        input logic               rd_acc
    );
        logic [USEDW_W-1:0] nxt;
        case ({wr_acc, rd_acc})
            2'b10:   nxt = cur + 16'd1;
            2'b01:   nxt = cur - 16'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/stackq_ram.sv
// -----------------------------------------------------------------------------
// stackq_ram: simple dual-port memory, one write port and one registered read
// port. The array itself is not reset; only the read register is.
// Read and write on the same edge at the same address return the old word.
//   clk_i, arstn_i  : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i   : read enable/address; q_o holds between reads
//   q_o             : registered read data
// -----------------------------------------------------------------------------
module stackq_ram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] q_o
);

    logic [DWIDTH-1:0] mem_q [0:(2**AWIDTH)-1];
    logic [DWIDTH-1:0] q_q;

    // Storage array write port (no reset on the array).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; samples the pre-write contents of the array.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            q_q <= {DWIDTH{1'b0}};
        end else if (re_i) begin
            q_q <= mem_q[raddr_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/stackq_buf.sv
// -----------------------------------------------------------------------------
// stackq_buf: registered-output buffer, run-time selectable FIFO or LIFO order.
//   clk_i, arstn_i        : clock (rising), async active-low reset
//   mode_i                : requested mode (0 FIFO, 1 LIFO), loaded when empty
//                           and no write is requested
//   wrreq_i, rdreq_i      : write/read requests; data_i write data
//   q_o                   : registered read data
//   mode_o                : active mode
//   empty_o, full_o, almost_empty_o, almost_full_o, usedw_o : status
//   ovf_o, udf_o          : sticky overflow/underflow flags, present only when
//                           the STACKQ_ERR_EN macro is defined
// -----------------------------------------------------------------------------
module stackq_buf
    import stackq_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int AWIDTH     = 3,
    parameter int AFULL_LVL  = 2**AWIDTH-1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              mode_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    input  logic [DWIDTH-1:0] data_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              mode_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [AWIDTH:0]   usedw_o
`ifdef STACKQ_ERR_EN
   ,output logic              ovf_o,
    output logic              udf_o
`endif
);

    localparam logic [AWIDTH:0] DEPTH_W  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AFULL_W  = (AWIDTH+1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] AEMPTY_W = (AWIDTH+1)'(AEMPTY_LVL);

    mode_t             mode_q, mode_d;
    logic [AWIDTH-1:0] wrpntr_q, wrpntr_d;   // stack pointer in LIFO mode
    logic [AWIDTH-1:0] rdpntr_q, rdpntr_d;
    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic              empty_q, full_q, aempty_q, afull_q;
    logic              wr_acc_s, rd_acc_s;
    logic [AWIDTH-1:0] waddr_s, raddr_s;

    assign rd_acc_s = rdreq_i && !empty_q;
    assign wr_acc_s = wrreq_i && (!full_q || rd_acc_s);
    assign usedw_d  = (AWIDTH+1)'(usedw_next(USEDW_W'(usedw_q), wr_acc_s, rd_acc_s));

    // Next-state for mode and pointers, plus RAM addressing per mode.
    always_comb begin
        mode_d   = mode_q;
        wrpntr_d = wrpntr_q;
        rdpntr_d = rdpntr_q;
        waddr_s  = wrpntr_q;
        raddr_s  = rdpntr_q;
        if (empty_q && !wrreq_i) begin
            // Idle and empty: take the requested mode and restart addressing.
            mode_d   = mode_t'(mode_i);
            wrpntr_d = {AWIDTH{1'b0}};
            rdpntr_d = {AWIDTH{1'b0}};
        end else if (mode_q == MODE_LIFO) begin
            // sp wraps to 0 at DEPTH in AWIDTH bits, so sp-1 still addresses
            // the top entry when full.
            case ({wr_acc_s, rd_acc_s})
                2'b11: begin
                    waddr_s = wrpntr_q - {{(AWIDTH-1){1'b0}}, 1'b1};
                    raddr_s = wrpntr_q - {{(AWIDTH-1){1'b0}}, 1'b1};
                end
                2'b10: begin
                    wrpntr_d = wrpntr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
                end
                2'b01: begin
                    raddr_s  = wrpntr_q - {{(AWIDTH-1){1'b0}}, 1'b1};
                    wrpntr_d = wrpntr_q - {{(AWIDTH-1){1'b0}}, 1'b1};
                end
                default: begin
                    wrpntr_d = wrpntr_q;
                end
            endcase
        end else begin
            if (wr_acc_s) begin
                wrpntr_d = wrpntr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
            end else begin
                wrpntr_d = wrpntr_q;
            end
            if (rd_acc_s) begin
                rdpntr_d = rdpntr_q + {{(AWIDTH-1){1'b0}}, 1'b1};
            end else begin
                rdpntr_d = rdpntr_q;
            end
        end
    end

    // Mode, pointer, fill level and status flag registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            mode_q   <= MODE_FIFO;
            wrpntr_q <= {AWIDTH{1'b0}};
            rdpntr_q <= {AWIDTH{1'b0}};
            usedw_q  <= {(AWIDTH+1){1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            wrpntr_q <= wrpntr_d;
            rdpntr_q <= rdpntr_d;
            usedw_q  <= usedw_d;
            empty_q  <= (usedw_d == {(AWIDTH+1){1'b0}});
            full_q   <= (usedw_d == DEPTH_W);
            aempty_q <= (usedw_d <= AEMPTY_W);
            afull_q  <= (usedw_d >= AFULL_W);
        end
    end

`ifdef STACKQ_ERR_EN
    logic ovf_q, udf_q;

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wrreq_i && full_q && !rd_acc_s) begin
                ovf_q <= 1'b1;
            end
            if (rdreq_i && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`endif

    stackq_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .we_i    (wr_acc_s),
        .waddr_i (waddr_s),
        .wdata_i (data_i),
        .re_i    (rd_acc_s),
        .raddr_i (raddr_s),
        .q_o     (q_o)
    );

    assign mode_o         = mode_q;
    assign usedw_o        = usedw_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;

endmodule
